// File: rtl/me_job_sequencer_if.sv
// me_job_sequencer_if: host job/result handshake plus estimator start/completed
// handshake. The sequencer connects through the master modport. The host and
// the estimator side connect through the slave modport.
interface me_job_sequencer_if #(
  parameter int DIST_W     = 8,
  parameter int MV_W       = 4,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic              job_valid;
  logic              job_ready;
  logic              start;
  logic              completed;
  logic [DIST_W-1:0] best_dist;
  logic [MV_W-1:0]   motion_x;
  logic [MV_W-1:0]   motion_y;
  logic              res_valid;
  logic              res_ready;
  logic [DIST_W-1:0] res_dist;
  logic [MV_W-1:0]   res_mx;
  logic [MV_W-1:0]   res_my;
  logic              res_timeout;
  logic              busy;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    input  job_valid, completed, best_dist, motion_x, motion_y, res_ready,
    output job_ready, start, res_valid, res_dist, res_mx, res_my, res_timeout,
           busy, fifo_count
  );

  modport slave (
    output job_valid, completed, best_dist, motion_x, motion_y, res_ready,
    input  job_ready, start, res_valid, res_dist, res_mx, res_my, res_timeout,
           busy, fifo_count
  );
endinterface

// File: rtl/me_job_sequencer.sv
// me_job_sequencer: issues one motion-estimation job at a time to the
// estimator. It holds start high until completed or until the watchdog
// expires. It then enforces a low gap on start. Each outcome is queued in a
// first-word-fall-through result FIFO.
// Optional build macro ME_STATS_EN adds the push and timeout counters
// stat_jobs and stat_timeouts.
module me_job_sequencer #(
  parameter int DIST_W         = 8,
  parameter int MV_W           = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 2
) (
  input logic clock,
  input logic reset,
  me_job_sequencer_if.master bus
`ifdef ME_STATS_EN
  ,
  output logic [15:0] stat_jobs,
  output logic [15:0] stat_timeouts
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int ENT_W = DIST_W + 2 * MV_W + 1;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

  state_t           r_state;
  logic             r_start;
  logic             r_busy;
  logic [TMR_W-1:0] r_timer;
  logic [GAP_W-1:0] r_gap;

  // An entry is packed as {dist, mx, my, timeout}.
  logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_res_valid;
  logic [ENT_W-1:0] r_head;

  logic             w_job_ready;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic [ENT_W-1:0] w_push_entry;
  logic [PTR_W-1:0] w_rd_ptr_next;
  logic [CNT_W-1:0] w_count_kept;
  logic [CNT_W-1:0] w_count_next;

  // A job may start only when the FIFO has room for its result. The
  // estimator must also have dropped completed from any earlier job.
  assign w_job_ready = !reset && (r_state == S_IDLE) && (r_count != CNT_FULL) &&
                       !bus.completed;
  assign w_accept    = w_job_ready && bus.job_valid;

  // If completed and the watchdog expire on the same edge, completed wins.
  assign w_push       = !reset && (r_state == S_RUN) &&
                        (bus.completed || (r_timer == TMR_LAST));
  assign w_push_entry = bus.completed ?
                        {bus.best_dist, bus.motion_x, bus.motion_y, 1'b0} :
                        {{DIST_W{1'b1}}, {MV_W{1'b0}}, {MV_W{1'b0}}, 1'b1};

  assign w_pop         = r_res_valid && bus.res_ready;
  assign w_rd_ptr_next = r_rd_ptr + PTR_W'(w_pop);
  assign w_count_kept  = r_count - CNT_W'(w_pop);
  assign w_count_next  = w_count_kept + CNT_W'(w_push);

  // Job sequencing FSM; start and busy are registered alongside the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_timer <= '0;
      r_gap   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_RUN;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_timer <= '0;
          end
        end
        S_RUN: begin
          if (w_push) begin
            r_state <= S_GAP;
            r_start <= 1'b0;
            r_gap   <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_GAP: begin
          // A completed flag that stays high pins the sequencer here. This
          // keeps a stale flag from being mistaken for the next job's result.
          if ((r_gap >= GAP_LAST) && !bus.completed) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_gap < GAP_LAST) begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_start <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Result storage array, written on push (no reset needed on contents).
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_entry;
    end
  end

  // FIFO pointers, occupancy and registered head.
  // When the pushed entry becomes the head at once, the array is bypassed.
  // With nothing left to show, the head keeps the last popped value.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_res_valid <= 1'b0;
      r_head      <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      r_rd_ptr    <= w_rd_ptr_next;
      r_count     <= w_count_next;
      r_res_valid <= (w_count_next != '0);
      if (w_count_kept == '0) begin
        if (w_push) begin
          r_head <= w_push_entry;
        end
      end else begin
        r_head <= r_mem[w_rd_ptr_next];
      end
    end
  end

  a_no_push_when_full: assert property (@(posedge clock) disable iff (reset)
    w_push |-> (r_count != CNT_FULL));

  assign bus.job_ready   = w_job_ready;
  assign bus.start       = r_start;
  assign bus.busy        = r_busy;
  assign bus.fifo_count  = r_count;
  assign bus.res_valid   = r_res_valid;
  assign bus.res_dist    = r_head[ENT_W-1 -: DIST_W];
  assign bus.res_mx      = r_head[2*MV_W : MV_W+1];
  assign bus.res_my      = r_head[MV_W : 1];
  assign bus.res_timeout = r_head[0];

`ifdef ME_STATS_EN
  logic [15:0] r_stat_jobs;
  logic [15:0] r_stat_timeouts;

  // Saturating counters of pushed results and of watchdog aborts.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stat_jobs     <= '0;
      r_stat_timeouts <= '0;
    end else if (w_push) begin
      if (r_stat_jobs != 16'hFFFF) begin
        r_stat_jobs <= r_stat_jobs + 16'd1;
      end
      if (w_push_entry[0] && (r_stat_timeouts != 16'hFFFF)) begin
        r_stat_timeouts <= r_stat_timeouts + 16'd1;
      end
    end
  end

  assign stat_jobs     = r_stat_jobs;
  assign stat_timeouts = r_stat_timeouts;
`endif

endmodule

// File: tb/tb_me_job_sequencer.sv
// tb_me_job_sequencer: runs directed and random job/estimator/host traffic.
// Outputs are checked each cycle against a queue-based model of the
// sequencer. Build with ME_STATS_EN defined to check the statistics counters too.
module tb_me_job_sequencer;
  localparam int DIST_W = 8;
  localparam int MV_W   = 4;
  localparam int DEPTH  = 4;
  localparam int TMO    = 16;
  localparam int GAP    = 2;

  typedef struct {
    logic [7:0] d;
    logic [3:0] mx;
    logic [3:0] my;
    logic       to;
  } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  me_job_sequencer_if #(.DIST_W(DIST_W), .MV_W(MV_W), .FIFO_DEPTH(DEPTH)) bus ();

`ifdef ME_STATS_EN
  logic [15:0] stat_jobs;
  logic [15:0] stat_timeouts;
`endif

  me_job_sequencer #(
    .DIST_W(DIST_W), .MV_W(MV_W), .FIFO_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
`ifdef ME_STATS_EN
    ,
    .stat_jobs(stat_jobs),
    .stat_timeouts(stat_timeouts)
`endif
  );

  // Model state: phase 0 = idle, 1 = start high, 2 = start low after a job.
  int   phase;
  int   high_cycles;
  int   low_cycles;
  int   hold_left;
  ent_t q[$];
  ent_t last;
  ent_t est;
  int   est_lat;
  int   est_hold;
  int   stat_j;
  int   stat_t;

  // Stimulus knobs.
  int   budget;
  int   jv_pct;
  int   rr_pct;
  int   spur_pct;
  int   rst_pm;
  int   force_lat;
  int   force_hold;
  bit   force_reset;
  bit   force_data;
  ent_t fdata;

  int n_checks;
  int n_errors;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_result(input ent_t e);
    q.push_back(e);
    if (stat_j < 16'hFFFF) stat_j++;
    if (e.to && stat_t < 16'hFFFF) stat_t++;
  endtask

  task automatic run_cycle();
    ent_t head;
    ent_t e;
    bit   jr;
    @(negedge clock);
    reset         = force_reset || ($urandom_range(999) < 32'(rst_pm));
    bus.job_valid = (budget > 0) && ($urandom_range(99) < 32'(jv_pct));
    bus.res_ready = ($urandom_range(99) < 32'(rr_pct));
    case (phase)
      1:       bus.completed = (high_cycles + 1 == est_lat);
      2:       bus.completed = (hold_left > 0);
      default: bus.completed = ($urandom_range(99) < 32'(spur_pct));
    endcase
    if (bus.completed && phase == 1) begin
      bus.best_dist = est.d;
      bus.motion_x  = est.mx;
      bus.motion_y  = est.my;
    end else begin
      bus.best_dist = 8'($urandom);
      bus.motion_x  = 4'($urandom);
      bus.motion_y  = 4'($urandom);
    end
    #1;
    head = (q.size() > 0) ? q[0] : last;
    check_val("start", 32'(bus.start), 32'(phase == 1));
    check_val("busy", 32'(bus.busy), 32'(phase != 0));
    check_val("job_ready", 32'(bus.job_ready),
              32'(!reset && phase == 0 && q.size() < DEPTH && !bus.completed));
    check_val("fifo_count", 32'(bus.fifo_count), 32'(q.size()));
    check_val("res_valid", 32'(bus.res_valid), 32'(q.size() > 0));
    check_val("res_dist", 32'(bus.res_dist), 32'(head.d));
    check_val("res_mx", 32'(bus.res_mx), 32'(head.mx));
    check_val("res_my", 32'(bus.res_my), 32'(head.my));
    check_val("res_timeout", 32'(bus.res_timeout), 32'(head.to));
`ifdef ME_STATS_EN
    check_val("stat_jobs", 32'(stat_jobs), 32'(stat_j));
    check_val("stat_timeouts", 32'(stat_timeouts), 32'(stat_t));
`endif
    @(posedge clock);
    if (reset) begin
      q.delete();
      phase     = 0;
      hold_left = 0;
      last      = '{d: 8'h00, mx: 4'h0, my: 4'h0, to: 1'b0};
      stat_j    = 0;
      stat_t    = 0;
    end else begin
      jr = (phase == 0) && (q.size() < DEPTH) && !bus.completed;
      if (q.size() > 0 && bus.res_ready) begin
        last = q.pop_front();
        $display("pop   dist=%02h mx=%0h my=%0h timeout=%0b", last.d, last.mx, last.my, last.to);
      end
      case (phase)
        0: begin
          if (jr && bus.job_valid) begin
            phase       = 1;
            high_cycles = 0;
            budget--;
            est_lat  = (force_lat >= 0) ? force_lat :
                       (($urandom_range(9) == 0) ? 1000 : int'($urandom_range(20, 1)));
            est_hold = (force_hold >= 0) ? force_hold : int'($urandom_range(3, 0));
            if (force_data) est = fdata;
            else est = '{d: 8'($urandom), mx: 4'($urandom), my: 4'($urandom), to: 1'b0};
            $display("job   lat=%0d dist=%02h mx=%0h my=%0h", est_lat, est.d, est.mx, est.my);
          end
        end
        1: begin
          high_cycles++;
          if (bus.completed) begin
            e = '{d: bus.best_dist, mx: bus.motion_x, my: bus.motion_y, to: 1'b0};
            push_result(e);
            phase      = 2;
            low_cycles = 0;
            hold_left  = est_hold;
          end else if (high_cycles == TMO) begin
            e = '{d: 8'hFF, mx: 4'h0, my: 4'h0, to: 1'b1};
            push_result(e);
            phase      = 2;
            low_cycles = 0;
            hold_left  = 0;
          end
        end
        default: begin
          low_cycles++;
          if (hold_left > 0) hold_left--;
          if (low_cycles >= GAP && !bus.completed) phase = 0;
        end
      endcase
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    phase = 0; high_cycles = 0; low_cycles = 0; hold_left = 0;
    last = '{d: 8'h00, mx: 4'h0, my: 4'h0, to: 1'b0};
    est  = last; est_lat = 1; est_hold = 0; stat_j = 0; stat_t = 0;
    budget = 0; jv_pct = 100; rr_pct = 0; spur_pct = 0; rst_pm = 0;
    force_lat = -1; force_hold = 0; force_reset = 1'b0; force_data = 1'b0; fdata = last;
    bus.job_valid = 1'b0; bus.completed = 1'b0; bus.res_ready = 1'b0;
    bus.best_dist = '0; bus.motion_x = '0; bus.motion_y = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);

    // Reset state, including job_ready low during the reset cycle.
    force_reset = 1'b1; run_cycle(); force_reset = 1'b0;

    // Single job, completed after 10 start cycles with 2A/D/2.
    force_lat = 10; force_data = 1'b1; fdata = '{d: 8'h2A, mx: 4'hD, my: 4'h2, to: 1'b0};
    budget = 1; rr_pct = 0;
    repeat (20) run_cycle();
    rr_pct = 100; repeat (3) run_cycle();
    force_data = 1'b0;

    // Four back-to-back jobs fill the FIFO; the fifth waits for a pop.
    force_lat = 3; budget = 5; rr_pct = 0;
    repeat (40) run_cycle();
    rr_pct = 100; run_cycle(); rr_pct = 0;
    repeat (15) run_cycle();
    rr_pct = 100; repeat (8) run_cycle();

    // Estimator never completes: watchdog entry, then a normal job.
    force_lat = 1000; budget = 1; repeat (22) run_cycle();
    force_lat = 2; budget = 1; repeat (8) run_cycle();

    // completed held high 5 cycles after a job.
    force_lat = 4; force_hold = 5; budget = 1; repeat (16) run_cycle();
    force_hold = 0;

    // Reset 3 cycles into RUN, then stray completed pulses.
    force_lat = 1000; budget = 1; repeat (4) run_cycle();
    force_reset = 1'b1; run_cycle(); force_reset = 1'b0;
    budget = 0; spur_pct = 50; repeat (10) run_cycle();
    spur_pct = 0;

    // completed on the last permitted RUN cycle.
    force_lat = TMO; budget = 1; repeat (22) run_cycle();

    // Random traffic.
    force_lat = -1; force_hold = -1; budget = 1000000;
    jv_pct = 60; rr_pct = 50; spur_pct = 5; rst_pm = 2;
    repeat (4000) run_cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/me_job_sequencer.md
Name: me_job_sequencer

Overview:
- Initiator side of the motion-estimator start/completed handshake; the estimator core is the responder.
- Accepts estimation jobs from a host over a valid/ready handshake and drives `start` to the estimator.
- Waits for `completed` (or a watchdog timeout), then captures BestDist/motionX/motionY into a result FIFO that the host drains.

Parameters:
- DIST_W, 8, width of the best-distance value
- MV_W, 4, width of each signed motion-vector component
- FIFO_DEPTH, 4, number of result entries (power of two, >= 2)
- TIMEOUT_CYCLES, 4096, maximum cycles `start` stays high before the job is aborted
- GAP_CYCLES, 2, minimum cycles `start` stays low between jobs

Ports:
- clock, in, 1, single clock, rising edge
- reset, in, 1, synchronous active-high reset
- job_valid, in, 1, host requests one estimation
- job_ready, out, 1, sequencer can accept a job
- start, out, 1, level start to the estimator
- completed, in, 1, estimator done flag
- best_dist, in, DIST_W, estimator BestDist
- motion_x, in, MV_W, estimator motionX (two's complement)
- motion_y, in, MV_W, estimator motionY (two's complement)
- res_valid, out, 1, FIFO head valid
- res_ready, in, 1, host pops FIFO head
- res_dist, out, DIST_W, head distance
- res_mx, out, MV_W, head motion x
- res_my, out, MV_W, head motion y
- res_timeout, out, 1, head entry was aborted by the watchdog
- busy, out, 1, state != IDLE
- fifo_count, out, $clog2(FIFO_DEPTH+1), occupied entries

Behaviour:
- Interface: one clock (`clock`); reset (`reset`) is synchronous and active-high.
- Reset: state=IDLE, start=0, busy=0, FIFO empty, fifo_count=0, res_valid=0, res_* = 0, timer=0, job_ready=0 during the reset cycle.
- States: IDLE, RUN, GAP.
- IDLE:
  - job_ready = (fifo_count < FIFO_DEPTH) && !completed.
  - A job is accepted on an edge with job_valid && job_ready; the next state is RUN, so `start` is 1 from the following cycle.
- RUN:
  - start=1; timer increments each cycle starting from 0.
  - completed=1 sampled: push {best_dist, motion_x, motion_y, timeout=0}; go to GAP.
  - Otherwise, when timer == TIMEOUT_CYCLES-1: push {all-ones DIST, 0, 0, timeout=1}; go to GAP.
  - Completed and the timeout both in the same cycle: completed wins, and timeout=0 is recorded.
- GAP:
  - start=0; the gap counter counts from 0.
  - Go to IDLE when the gap counter >= GAP_CYCLES-1 and completed==0.
  - If completed stays high, remain in GAP indefinitely.
- job_ready=0 in RUN and GAP; only one job is in flight.
- FIFO:
  - Registered, first-word-fall-through.
  - A pushed entry is visible on res_* with res_valid=1 on the cycle after the push edge.
  - Pop happens on res_valid && res_ready.
  - Pop while empty is ignored.
  - Push and pop in the same cycle: fifo_count is unchanged and order is preserved.
  - Overflow cannot occur because of the job_ready gating. An assertion is required that push never occurs while full.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- res_* hold their values while res_valid=0 (last popped value or reset 0).
- Latency: accept edge k → start=1 in cycle k+1 → completed sampled at edge m → res_valid=1 in cycle m+1 (when the FIFO was empty).
- Reset mid-RUN: start is 0 after the reset edge, the FIFO is flushed, and the in-flight result is discarded.
- Motion vectors are stored bit-exact; no sign extension is applied.

Optional Feature:
- ME_STATS_EN:
  - Defined: adds output ports stat_jobs[15:0] and stat_timeouts[15:0].
  - Both counters reset to 0 and saturate at 16'hFFFF.
  - stat_jobs increments on every FIFO push; stat_timeouts increments on pushes with timeout=1.
- Undefined: those ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Single job, estimator model asserts completed 10 cycles after start with dist=8'h2A, mx=4'hD (−3), my=4'h2 → start high 10 cycles; res_valid one cycle after completed with 2A/D/2, timeout=0; fifo_count=1.
- Four back-to-back jobs, host res_ready=0 → fifo_count reaches 4; job_ready=0; a fifth job_valid is held off; one pop → job_ready returns to 1 and the fifth job runs.
- Estimator never completes, TIMEOUT_CYCLES=16 → start high exactly 16 cycles; entry FF/0/0 with timeout=1; start low for >= 2 cycles; next job is accepted.
- completed left high after a job for 5 cycles → sequencer stays in GAP and job_ready=0 until completed falls, then IDLE.
- reset asserted 3 cycles into RUN → after the reset edge start=0, fifo_count=0, res_valid=0, busy=0; a later completed pulse produces no push.
- With ME_STATS_EN, 3 normal jobs + 1 timeout → stat_jobs=4, stat_timeouts=1; simultaneous completed and timeout on the last RUN cycle → timeout=0 and stat_timeouts is unchanged.
